// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register and operand-select stage of the lx32 core.
// Holds one decoded instruction, applies MEM/WB forwarding and drives the ALU operands.

package lx32_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;
endpackage

package branches_pkg;
    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd2,
        BR_GE  = 3'd3,
        BR_LTU = 3'd4,
        BR_GEU = 3'd5
    } branch_op_e;
endpackage

module ex_operand_stage #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,

    input  logic                     id_valid,
    output logic                     id_ready,
    input  logic [WIDTH-1:0]         id_pc,
    input  logic [WIDTH-1:0]         id_rs1_data,
    input  logic [WIDTH-1:0]         id_rs2_data,
    input  logic [WIDTH-1:0]         id_imm,
    input  logic [4:0]               id_rs1_addr,
    input  logic [4:0]               id_rs2_addr,
    input  logic [4:0]               id_rd_addr,
    input  lx32_pkg::alu_op_e        id_alu_control,
    input  logic                     id_is_branch,
    input  branches_pkg::branch_op_e id_branch_op,
    input  logic                     id_src_a_pc,
    input  logic                     id_src_b_imm,
    input  logic                     id_reg_write,

    input  logic                     mem_fwd_we,
    input  logic [4:0]               mem_fwd_rd,
    input  logic [WIDTH-1:0]         mem_fwd_data,
    input  logic                     wb_fwd_we,
    input  logic [4:0]               wb_fwd_rd,
    input  logic [WIDTH-1:0]         wb_fwd_data,

    input  logic                     ex_ready,
    output logic                     ex_valid,
    output logic [WIDTH-1:0]         src_a,
    output logic [WIDTH-1:0]         src_b,
    output lx32_pkg::alu_op_e        alu_control,
    output logic                     is_branch,
    output branches_pkg::branch_op_e branch_op,
    output logic [WIDTH-1:0]         ex_pc,
    output logic [WIDTH-1:0]         ex_imm,
    output logic [WIDTH-1:0]         ex_store_data,
    output logic [4:0]               ex_rd_addr,
    output logic                     ex_reg_write
);
    import lx32_pkg::*;
    import branches_pkg::*;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] rs1_data;
        logic [WIDTH-1:0] rs2_data;
        logic [WIDTH-1:0] imm;
        logic [4:0]       rs1_addr;
        logic [4:0]       rs2_addr;
        logic [4:0]       rd_addr;
        alu_op_e          alu_control;
        logic             is_branch;
        branch_op_e       branch_op;
        logic             src_a_pc;
        logic             src_b_imm;
        logic             reg_write;
    } payload_t;

    localparam payload_t PAYLOAD_RESET = '{
        pc:          '0,
        rs1_data:    '0,
        rs2_data:    '0,
        imm:         '0,
        rs1_addr:    '0,
        rs2_addr:    '0,
        rd_addr:     '0,
        alu_control: ALU_ADD,
        is_branch:   1'b0,
        branch_op:   BR_EQ,
        src_a_pc:    1'b0,
        src_b_imm:   1'b0,
        reg_write:   1'b0
    };

    payload_t         held;
    payload_t         incoming;
    logic             valid_q;
    logic             load;
    logic             stall;
    logic [WIDTH-1:0] rs1_fwd;
    logic [WIDTH-1:0] rs2_fwd;

    // MEM is the younger producer, so it wins over WB; x0 is hardwired zero and never forwarded.
    function automatic logic [WIDTH-1:0] forward(
        input logic [4:0]       addr,
        input logic [WIDTH-1:0] held_data,
        input logic             m_we,
        input logic [4:0]       m_rd,
        input logic [WIDTH-1:0] m_data,
        input logic             w_we,
        input logic [4:0]       w_rd,
        input logic [WIDTH-1:0] w_data
    );
        if (m_we && (m_rd == addr) && (addr != 5'd0)) begin
            return m_data;
        end else if (w_we && (w_rd == addr) && (addr != 5'd0)) begin
            return w_data;
        end
        return held_data;
    endfunction

    assign id_ready = !valid_q || ex_ready || flush;
    assign load     = id_valid && id_ready && !flush;
    assign stall    = valid_q && !ex_ready;

    always_comb begin
        incoming             = PAYLOAD_RESET;
        incoming.pc          = id_pc;
        incoming.rs1_data    = id_rs1_data;
        incoming.rs2_data    = id_rs2_data;
        incoming.imm         = id_imm;
        incoming.rs1_addr    = id_rs1_addr;
        incoming.rs2_addr    = id_rs2_addr;
        incoming.rd_addr     = id_rd_addr;
        incoming.alu_control = id_alu_control;
        incoming.is_branch   = id_is_branch;
        incoming.branch_op   = id_branch_op;
        incoming.src_a_pc    = id_src_a_pc;
        incoming.src_b_imm   = id_src_b_imm;
        incoming.reg_write   = id_reg_write;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end else if (valid_q && ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    // NOTE: the payload is reset too, because its reset values are visible on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            held <= PAYLOAD_RESET;
        end else if (load) begin
            held <= incoming;
        end else if (stall) begin
            // Capture forwarded values so a producer retiring during the stall is not lost.
            held.rs1_data <= rs1_fwd;
            held.rs2_data <= rs2_fwd;
        end
    end

    assign rs1_fwd = forward(held.rs1_addr, held.rs1_data, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                             wb_fwd_we, wb_fwd_rd, wb_fwd_data);
    assign rs2_fwd = forward(held.rs2_addr, held.rs2_data, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                             wb_fwd_we, wb_fwd_rd, wb_fwd_data);

    assign ex_valid      = valid_q;
    assign src_a         = held.src_a_pc  ? held.pc  : rs1_fwd;
    assign src_b         = held.src_b_imm ? held.imm : rs2_fwd;
    assign ex_store_data = rs2_fwd;
    assign alu_control   = held.alu_control;
    assign branch_op     = held.branch_op;
    assign is_branch     = held.is_branch && valid_q;
    assign ex_reg_write  = held.reg_write && valid_q;
    assign ex_pc         = held.pc;
    assign ex_imm        = held.imm;
    assign ex_rd_addr    = held.rd_addr;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed testbench for ex_operand_stage: handshake, forwarding, stall refresh,
// operand select, flush and reset behaviour against hand-computed values.

module tb_ex_operand_stage;
    import lx32_pkg::*;
    import branches_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [4:0]  id_rd_addr;
    alu_op_e     id_alu_control;
    logic        id_is_branch;
    branch_op_e  id_branch_op;
    logic        id_src_a_pc;
    logic        id_src_b_imm;
    logic        id_reg_write;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_we;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] src_a;
    logic [31:0] src_b;
    alu_op_e     alu_control;
    logic        is_branch;
    branch_op_e  branch_op;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write;

    int passed = 0;
    int total  = 0;

    ex_operand_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_control(id_alu_control), .id_is_branch(id_is_branch), .id_branch_op(id_branch_op),
        .id_src_a_pc(id_src_a_pc), .id_src_b_imm(id_src_b_imm), .id_reg_write(id_reg_write),
        .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .ex_ready(ex_ready), .ex_valid(ex_valid),
        .src_a(src_a), .src_b(src_b), .alu_control(alu_control),
        .is_branch(is_branch), .branch_op(branch_op),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_store_data(ex_store_data),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1d,
                         input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [31:0] imm,
                         input logic [4:0] rd, input alu_op_e op, input logic br,
                         input branch_op_e bop, input logic sa, input logic sb, input logic rw);
        id_valid       = 1'b1;
        id_pc          = pc;
        id_rs1_addr    = rs1a;
        id_rs1_data    = rs1d;
        id_rs2_addr    = rs2a;
        id_rs2_data    = rs2d;
        id_imm         = imm;
        id_rd_addr     = rd;
        id_alu_control = op;
        id_is_branch   = br;
        id_branch_op   = bop;
        id_src_a_pc    = sa;
        id_src_b_imm   = sb;
        id_reg_write   = rw;
    endtask

    task automatic fwd_idle();
        mem_fwd_we = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'h0;
        wb_fwd_we  = 1'b0; wb_fwd_rd  = 5'd0; wb_fwd_data  = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        offer(32'h44, 5'd1, 32'h99, 5'd2, 32'h98, 32'h4, 5'd3, ALU_SUB, 1'b1, BR_NE, 1'b0, 1'b0, 1'b1);
        fwd_idle();
        step();
        total++; if (id_ready !== 1'b1) $display("FAIL reset_id_ready_during: got %0b want 1", id_ready); else passed++;
        step();
        rst = 1'b0; id_valid = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid: got %0b want 0", ex_valid); else passed++;
        total++; if (is_branch !== 1'b0) $display("FAIL reset_is_branch: got %0b want 0", is_branch); else passed++;
        total++; if (ex_reg_write !== 1'b0) $display("FAIL reset_reg_write: got %0b want 0", ex_reg_write); else passed++;
        total++; if (src_a !== 32'h0) $display("FAIL reset_src_a: got %h want 0", src_a); else passed++;
        total++; if (ex_pc !== 32'h0) $display("FAIL reset_ex_pc: got %h want 0", ex_pc); else passed++;
        total++; if (ex_rd_addr !== 5'd0) $display("FAIL reset_rd_addr: got %0d want 0", ex_rd_addr); else passed++;
        total++; if (alu_control !== ALU_ADD) $display("FAIL reset_alu_control: got %0d want %0d", alu_control, ALU_ADD); else passed++;
        total++; if (branch_op !== BR_EQ) $display("FAIL reset_branch_op: got %0d want %0d", branch_op, BR_EQ); else passed++;
        total++; if (id_ready !== 1'b1) $display("FAIL reset_id_ready_after: got %0b want 1", id_ready); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        ex_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            want = 32'(i);
            offer(32'h1000 + 32'(4 * i), 5'd1, want, 5'd2, 32'h0, 32'h0, 5'd4, ALU_ADD,
                  1'b0, BR_EQ, 1'b0, 1'b0, 1'b1);
            step();
            total++; if (src_a !== want) $display("FAIL b2b_src_a_%0d: got %h want %h", i, src_a, want); else passed++;
            total++; if (ex_valid !== 1'b1) $display("FAIL b2b_valid_%0d: got %0b want 1", i, ex_valid); else passed++;
            total++; if (id_ready !== 1'b1) $display("FAIL b2b_id_ready_%0d: got %0b want 1", i, id_ready); else passed++;
        end
        total++; if (ex_reg_write !== 1'b1) $display("FAIL b2b_reg_write: got %0b want 1", ex_reg_write); else passed++;
        id_valid = 1'b0;
        step();
        total++; if (ex_valid !== 1'b0) $display("FAIL b2b_drain_valid: got %0b want 0", ex_valid); else passed++;
        total++; if (ex_reg_write !== 1'b0) $display("FAIL b2b_drain_reg_write: got %0b want 0", ex_reg_write); else passed++;
    endtask

    task automatic test_forward_priority();
        ex_ready = 1'b1;
        offer(32'h200, 5'd5, 32'h10, 5'd0, 32'h0, 32'h0, 5'd6, ALU_ADD, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b1);
        step();
        id_valid = 1'b0; ex_ready = 1'b0;
        #1;
        total++; if (src_a !== 32'h10) $display("FAIL fwd_held: got %h want 10", src_a); else passed++;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'h20;
        wb_fwd_we  = 1'b1; wb_fwd_rd  = 5'd5; wb_fwd_data  = 32'h30;
        #1;
        total++; if (src_a !== 32'h20) $display("FAIL fwd_mem_over_wb: got %h want 20", src_a); else passed++;
        mem_fwd_we = 1'b0;
        #1;
        total++; if (src_a !== 32'h30) $display("FAIL fwd_wb_only: got %h want 30", src_a); else passed++;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; wb_fwd_rd = 5'd0;
        #1;
        total++; if (src_a !== 32'h10) $display("FAIL fwd_x0_ignored: got %h want 10", src_a); else passed++;
        fwd_idle();
        ex_ready = 1'b1;
        step();
    endtask

    task automatic test_stall_refresh();
        ex_ready = 1'b1;
        offer(32'h300, 5'd0, 32'h0, 5'd7, 32'h1111, 32'h0, 5'd8, ALU_OR, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b1);
        step();
        ex_ready = 1'b0;
        offer(32'h304, 5'd9, 32'hBEEF, 5'd0, 32'h0, 32'h0, 5'd10, ALU_XOR, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b1);
        wb_fwd_we = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'hDEAD;
        #1;
        total++; if (id_ready !== 1'b0) $display("FAIL stall_id_ready_0: got %0b want 0", id_ready); else passed++;
        step();
        fwd_idle();
        #1;
        total++; if (src_b !== 32'hDEAD) $display("FAIL stall_refresh_1: got %h want dead", src_b); else passed++;
        total++; if (id_ready !== 1'b0) $display("FAIL stall_id_ready_1: got %0b want 0", id_ready); else passed++;
        step();
        total++; if (src_b !== 32'hDEAD) $display("FAIL stall_refresh_2: got %h want dead", src_b); else passed++;
        total++; if (ex_pc !== 32'h300) $display("FAIL stall_payload_kept: got %h want 300", ex_pc); else passed++;
        total++; if (ex_valid !== 1'b1) $display("FAIL stall_valid: got %0b want 1", ex_valid); else passed++;
        id_valid = 1'b0; ex_ready = 1'b1;
        #1;
        total++; if (src_b !== 32'hDEAD) $display("FAIL stall_handoff_src_b: got %h want dead", src_b); else passed++;
        total++; if (id_ready !== 1'b1) $display("FAIL stall_release_ready: got %0b want 1", id_ready); else passed++;
        step();
        total++; if (ex_valid !== 1'b0) $display("FAIL stall_after_handoff: got %0b want 0", ex_valid); else passed++;
    endtask

    task automatic test_operand_select();
        ex_ready = 1'b1;
        offer(32'h100, 5'd2, 32'h77, 5'd3, 32'h0, 32'h8, 5'd11, ALU_ADD, 1'b0, BR_EQ, 1'b1, 1'b1, 1'b1);
        step();
        id_valid = 1'b0; ex_ready = 1'b0;
        mem_fwd_we = 1'b1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'h55;
        #1;
        total++; if (src_a !== 32'h100) $display("FAIL opsel_src_a: got %h want 100", src_a); else passed++;
        total++; if (src_b !== 32'h8) $display("FAIL opsel_src_b: got %h want 8", src_b); else passed++;
        total++; if (ex_store_data !== 32'h55) $display("FAIL opsel_store: got %h want 55", ex_store_data); else passed++;
        total++; if (ex_imm !== 32'h8) $display("FAIL opsel_imm: got %h want 8", ex_imm); else passed++;
        total++; if (ex_rd_addr !== 5'd11) $display("FAIL opsel_rd: got %0d want 11", ex_rd_addr); else passed++;
        fwd_idle();
        ex_ready = 1'b1;
        step();
    endtask

    task automatic test_flush();
        ex_ready = 1'b1;
        offer(32'h400, 5'd1, 32'h1, 5'd2, 32'h2, 32'h10, 5'd0, ALU_SUB, 1'b1, BR_NE, 1'b0, 1'b0, 1'b1);
        step();
        total++; if (is_branch !== 1'b1) $display("FAIL flush_pre_branch: got %0b want 1", is_branch); else passed++;
        total++; if (branch_op !== BR_NE) $display("FAIL flush_pre_br_op: got %0d want %0d", branch_op, BR_NE); else passed++;
        ex_ready = 1'b0; flush = 1'b1;
        offer(32'h500, 5'd3, 32'h3, 5'd4, 32'h4, 32'h0, 5'd12, ALU_AND, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b1);
        #1;
        total++; if (id_ready !== 1'b1) $display("FAIL flush_id_ready: got %0b want 1", id_ready); else passed++;
        step();
        flush = 1'b0; id_valid = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0) $display("FAIL flush_valid: got %0b want 0", ex_valid); else passed++;
        total++; if (is_branch !== 1'b0) $display("FAIL flush_is_branch: got %0b want 0", is_branch); else passed++;
        total++; if (ex_reg_write !== 1'b0) $display("FAIL flush_reg_write: got %0b want 0", ex_reg_write); else passed++;
        total++; if (ex_pc === 32'h500) $display("FAIL flush_offered_absent: got %h want not 500", ex_pc); else passed++;
        step();
        total++; if (ex_valid !== 1'b0) $display("FAIL flush_stays_empty: got %0b want 0", ex_valid); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        ex_ready = 1'b1;
        offer(32'h600, 5'd1, 32'h77, 5'd2, 32'h0, 32'h0, 5'd13, ALU_SUB, 1'b1, BR_LT, 1'b0, 1'b0, 1'b1);
        step();
        ex_ready = 1'b0;
        offer(32'h700, 5'd1, 32'h88, 5'd2, 32'h0, 32'h0, 5'd14, ALU_OR, 1'b0, BR_EQ, 1'b0, 1'b0, 1'b1);
        step();
        total++; if (src_a !== 32'h77) $display("FAIL rst_stall_pre_src_a: got %h want 77", src_a); else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0; id_valid = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0) $display("FAIL rst_stall_valid: got %0b want 0", ex_valid); else passed++;
        total++; if (src_a !== 32'h0) $display("FAIL rst_stall_src_a: got %h want 0", src_a); else passed++;
        total++; if (alu_control !== ALU_ADD) $display("FAIL rst_stall_alu: got %0d want %0d", alu_control, ALU_ADD); else passed++;
        total++; if (id_ready !== 1'b1) $display("FAIL rst_stall_id_ready: got %0b want 1", id_ready); else passed++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_forward_priority();
        test_stall_refresh();
        test_operand_select();
        test_flush();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
